// File: rtl/reset_sequencer_if.sv
// Purpose : bundles the PLL lock input and the sequenced reset / status outputs of reset_sequencer.
// Latency : n/a (wiring only).
// Backpressure: none; all signals are level-style, no handshake.
//
// Signals:
//   pll_locked_i     PLL lock, asynchronous to the sequencer clock
//   stage_reset_n_o  active-low stage resets, bit 0 released first
//   ready_o          all stages released
//   fault_o          lock timeout occurred
// Modports: master = reset_sequencer side, slave = consumer / PLL side.
interface reset_sequencer_if #(
    parameter int STAGES = 3
);
    logic              pll_locked_i;
    logic [STAGES-1:0] stage_reset_n_o;
    logic              ready_o;
    logic              fault_o;

    modport master (
        input  pll_locked_i,
        output stage_reset_n_o,
        output ready_o,
        output fault_o
    );

    modport slave (
        output pll_locked_i,
        input  stage_reset_n_o,
        input  ready_o,
        input  fault_o
    );
endinterface

// File: rtl/reset_sequencer.sv
// Purpose : releases STAGES downstream resets in order once the PLL lock is seen, spaced STAGE_DELAY cycles.
// Latency : lock -> RELEASE entry 2 edges; stage k released STAGE_DELAY*(k+1) edges after that; lock loss clears in 2 edges.
// Backpressure: none; outputs are registered levels, lock loss re-asserts every stage, missing lock raises fault_o.
//
// Ports:
//   clk_i    sole clock
//   reset_i  asynchronous active-high reset (synchronized upstream)
//   seq_if   reset_sequencer_if.master: pll_locked_i in; stage_reset_n_o, ready_o, fault_o out
// Build option: RESET_SEQUENCER_RETRY_EN - when defined, a lock seen in FAULT restarts the release
//   sequence; fault_o stays sticky until reset_i. Undefined: FAULT is terminal until reset_i.
module reset_sequencer #(
    parameter int STAGES       = 3,
    parameter int STAGE_DELAY  = 16,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    reset_sequencer_if.master     seq_if
);
    localparam int TO_W = $clog2(LOCK_TIMEOUT);
    localparam int DL_W = $clog2(STAGE_DELAY + 1);
    localparam int IX_W = $clog2(STAGES + 1);

    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [DL_W-1:0]   DL_LOAD   = DL_W'(STAGE_DELAY - 1);
    localparam logic [IX_W-1:0]   IX_LAST   = IX_W'(STAGES - 1);
    localparam logic [STAGES-1:0] STAGE_ONE = STAGES'(1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WAIT   = 3'd1;
    localparam logic [2:0] ST_REL    = 3'd2;
    localparam logic [2:0] ST_RUN    = 3'd3;
    localparam logic [2:0] ST_FAULT  = 3'd4;

    logic [2:0]        r_state;
    logic              r_sync_1;
    logic              r_lock_s;
    logic [TO_W-1:0]   r_to_cnt;
    logic [DL_W-1:0]   r_dly_cnt;
    logic [IX_W-1:0]   r_idx;
    logic [STAGES-1:0] r_stage;
    logic              r_ready;
    logic              r_fault;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state   <= ST_IDLE;
            r_sync_1  <= 1'b0;
            r_lock_s  <= 1'b0;
            r_to_cnt  <= '0;
            r_dly_cnt <= '0;
            r_idx     <= '0;
            r_stage   <= '0;
            r_ready   <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            // Two-flop synchronizer; r_lock_s is the only lock view the FSM uses.
            r_sync_1 <= seq_if.pll_locked_i;
            r_lock_s <= r_sync_1;

            case (r_state)
                ST_IDLE: begin
                    r_state  <= ST_WAIT;
                    r_to_cnt <= '0;
                end

                ST_WAIT: begin
                    // Lock is tested first so it wins a tie with the final timeout cycle.
                    if (r_lock_s) begin
                        r_state   <= ST_REL;
                        r_dly_cnt <= DL_LOAD;
                        r_idx     <= '0;
                    end else if (r_to_cnt == TO_LAST) begin
                        r_state <= ST_FAULT;
                        r_fault <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end

                ST_REL: begin
                    if (!r_lock_s) begin
                        r_state  <= ST_WAIT;
                        r_to_cnt <= '0;
                        r_idx    <= '0;
                        r_stage  <= '0;
                    end else if (r_dly_cnt == '0) begin
                        r_stage   <= r_stage | (STAGE_ONE << r_idx);
                        r_dly_cnt <= DL_LOAD;
                        if (r_idx == IX_LAST) begin
                            // Last stage out: ready rises on the same edge.
                            r_state <= ST_RUN;
                            r_ready <= 1'b1;
                            r_idx   <= '0;
                        end else begin
                            r_idx <= r_idx + IX_W'(1);
                        end
                    end else begin
                        r_dly_cnt <= r_dly_cnt - DL_W'(1);
                    end
                end

                ST_RUN: begin
                    if (!r_lock_s) begin
                        r_state  <= ST_WAIT;
                        r_to_cnt <= '0;
                        r_idx    <= '0;
                        r_stage  <= '0;
                        r_ready  <= 1'b0;
                    end
                end

                ST_FAULT: begin
`ifdef RESET_SEQUENCER_RETRY_EN
                    // Late lock restarts the sequence; r_fault is left set on purpose.
                    if (r_lock_s) begin
                        r_state   <= ST_REL;
                        r_dly_cnt <= DL_LOAD;
                        r_idx     <= '0;
                        r_stage   <= '0;
                    end
`else
                    // Terminal: only reset_i leaves this state.
                    r_stage <= '0;
`endif
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign seq_if.stage_reset_n_o = r_stage;
    assign seq_if.ready_o         = r_ready;
    assign seq_if.fault_o         = r_fault;

endmodule

// File: tb/tb_reset_sequencer.sv
// Purpose : scoreboard bench for reset_sequencer (STAGES=3, STAGE_DELAY=4, LOCK_TIMEOUT=32).
// Latency : n/a.
// Backpressure: n/a; the monitor compares every output change against the next expected transition.
module tb_reset_sequencer;
    logic clk_i;
    logic reset_i;
    int   edge_n;
    int   checks;
    int   failures;

    typedef struct {
        int         cyc;
        logic [2:0] st;
        logic       rdy;
        logic       flt;
    } exp_t;

    exp_t exp_q[$];

    reset_sequencer_if #(.STAGES(3)) seq_if();

    reset_sequencer #(
        .STAGES       (3),
        .STAGE_DELAY  (4),
        .LOCK_TIMEOUT (32)
    ) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .seq_if  (seq_if)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial edge_n = 0;
    always @(posedge clk_i) edge_n++;

    task automatic expect_at(input int cyc, input logic [2:0] st, input logic rdy, input logic flt);
        exp_t e;
        e.cyc = cyc;
        e.st  = st;
        e.rdy = rdy;
        e.flt = flt;
        exp_q.push_back(e);
    endtask

    task automatic check_outs(input string name, input logic [4:0] got, input logic [4:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s edge=%0d got={stage,rdy,flt}=%b want=%b", name, edge_n, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Leaves the caller at the falling edge following posedge number n.
    task automatic goto_neg(input int n);
        do @(negedge clk_i); while (edge_n < n);
    endtask

    task automatic set_lock(input int n, input logic v);
        goto_neg(n - 1);
        seq_if.pll_locked_i = v;
    endtask

    // Short reset pulse placed between posedge n and posedge n+1.
    task automatic pulse_reset(input int n);
        goto_neg(n - 1);
        @(posedge clk_i);
        #2 reset_i = 1'b1;
        #1 check_outs("reset_pulse_outputs",
                      {seq_if.stage_reset_n_o, seq_if.ready_o, seq_if.fault_o}, 5'b0);
        #1 reset_i = 1'b0;
    endtask

    // Monitor: every observed output change must match the head of the queue.
    initial begin
        logic [4:0] prev;
        logic [4:0] cur;
        exp_t       e;
        prev = '0;
        forever begin
            @(negedge clk_i);
            cur = {seq_if.stage_reset_n_o, seq_if.ready_o, seq_if.fault_o};
            if (cur !== prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_change edge=%0d got=%b prev=%b", edge_n, cur, prev);
                end else begin
                    e = exp_q.pop_front();
                    check_int("transition_edge", edge_n, e.cyc);
                    check_outs("transition_value", cur, {e.st, e.rdy, e.flt});
                end
                prev = cur;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog edge=%0d", edge_n);
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks              = 0;
        failures            = 0;
        reset_i             = 1'b1;
        seq_if.pll_locked_i = 1'b0;
        #1 check_outs("reset_state", {seq_if.stage_reset_n_o, seq_if.ready_o, seq_if.fault_o}, 5'b0);
        #1 reset_i = 1'b0;              // WAIT_LOCK entered at edge 1

        // Release sequence: lock at 10, RELEASE at 12.
        expect_at(16, 3'b001, 1'b0, 1'b0);
        expect_at(20, 3'b011, 1'b0, 1'b0);
        expect_at(24, 3'b111, 1'b1, 1'b0);
        set_lock(10, 1'b1);

        // Lock loss in RUN: drop at 40, cleared at 42.
        expect_at(42, 3'b000, 1'b0, 1'b0);
        set_lock(40, 1'b0);

        // Re-raise at 46: RELEASE at 48, stage 0 at 52.
        expect_at(52, 3'b001, 1'b0, 1'b0);
        set_lock(46, 1'b1);

        // One-cycle glitch at 54: all stages clear at 56, RELEASE again at 57, k restarts at 0.
        expect_at(56, 3'b000, 1'b0, 1'b0);
        expect_at(61, 3'b001, 1'b0, 1'b0);
        expect_at(65, 3'b011, 1'b0, 1'b0);
        expect_at(69, 3'b111, 1'b1, 1'b0);
        set_lock(54, 1'b0);
        set_lock(55, 1'b1);

        // Async reset mid-RELEASE: drop at 80 (clear 82), re-raise at 90 (RELEASE 92, stage 0 at 96).
        expect_at(82, 3'b000, 1'b0, 1'b0);
        set_lock(80, 1'b0);
        expect_at(96, 3'b001, 1'b0, 1'b0);
        set_lock(90, 1'b1);
        // Pulse between 97 and 98; lock still high -> WAIT at 98, RELEASE at 100.
        expect_at(97, 3'b000, 1'b0, 1'b0);
        expect_at(104, 3'b001, 1'b0, 1'b0);
        expect_at(108, 3'b011, 1'b0, 1'b0);
        expect_at(112, 3'b111, 1'b1, 1'b0);
        pulse_reset(97);

        // Timeout: drop at 120, WAIT at 122, FAULT 32 edges later at 154; then quiet.
        expect_at(122, 3'b000, 1'b0, 1'b0);
        expect_at(154, 3'b000, 1'b0, 1'b1);
        set_lock(120, 1'b0);

        // Late lock at 260 after >100 quiet cycles in FAULT.
`ifdef RESET_SEQUENCER_RETRY_EN
        expect_at(266, 3'b001, 1'b0, 1'b1);
        expect_at(270, 3'b011, 1'b0, 1'b1);
        expect_at(274, 3'b111, 1'b1, 1'b1);
        expect_at(288, 3'b000, 1'b0, 1'b1);
`endif
        set_lock(260, 1'b1);
        set_lock(286, 1'b0);

        // Reset clears the fault; new WAIT entered at 291.
        expect_at(290, 3'b000, 1'b0, 1'b0);
        pulse_reset(290);

        // Tie: lock_s rises while counter==31 (after edge 322) -> RELEASE at 323, no fault.
        expect_at(327, 3'b001, 1'b0, 1'b0);
        expect_at(331, 3'b011, 1'b0, 1'b0);
        expect_at(335, 3'b111, 1'b1, 1'b0);
        set_lock(321, 1'b1);

        goto_neg(350);
        check_int("pending_expectations", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Releases a set of downstream block resets in a fixed order once the pixel-clock PLL reports lock. It sits directly downstream of the per-domain reset synchronizer: the synchronized, inverted reset drives `reset_i`. Each stage reset is held low until the lock has been seen and the preceding stage has been out of reset for a programmable number of cycles. Loss of lock re-asserts every stage, and a lock that never arrives raises a fault.

## Interface
- `STAGES`, default 3: number of sequenced reset outputs; must be ≥1.
- `STAGE_DELAY`, default 16: cycles between successive stage releases; must be ≥1.
- `LOCK_TIMEOUT`, default 1024: cycles allowed in WAIT_LOCK before FAULT; must be ≥2.

Ports (one clock; reset is asynchronous and active-high):
- `clk_i` input 1: sole clock.
- `reset_i` input 1: asynchronous, active-high reset.
- `pll_locked_i` input 1: PLL lock, asynchronous to `clk_i`; synchronized internally.
- `stage_reset_n_o` output STAGES: active-low resets; bit 0 releases first.
- `ready_o` output 1: high while all stages are released (state RUN).
- `fault_o` output 1: lock timeout occurred.

## Operation
- Lock synchronizer: two flops, both cleared by `reset_i`. `lock_s` is the second flop.
- States: IDLE, WAIT_LOCK, RELEASE, RUN, FAULT. Encoding is free.
- IDLE: entered while `reset_i` is high. At the first clock edge after `reset_i` falls, go to WAIT_LOCK.
- WAIT_LOCK: the timeout counter starts at 0 on entry and increments each cycle.
  - `lock_s`=1 → RELEASE. Lock wins over a simultaneous timeout.
  - Counter == LOCK_TIMEOUT-1 with `lock_s`=0 → FAULT.
- RELEASE: the delay counter loads STAGE_DELAY-1 on entry and decrements each cycle.
  - At counter==0: set `stage_reset_n_o[k]`, increment k, and reload the counter.
  - Releasing bit STAGES-1 moves to RUN on the same edge.
  - `lock_s`=0 → WAIT_LOCK with all stage bits cleared and k=0.
- RUN: `lock_s`=0 → WAIT_LOCK. On that edge all stage bits clear and `ready_o` falls.
- FAULT: `fault_o`=1 and all stages stay in reset. Exit only by `reset_i`, unless the build option in Configuration is enabled.
- Counter widths:
  - Timeout counter: `$clog2(LOCK_TIMEOUT)` bits.
  - Delay counter: `$clog2(STAGE_DELAY+1)` bits.
  - Stage index: `$clog2(STAGES+1)` bits.
  - Counters never wrap: the timeout counter is consumed at LOCK_TIMEOUT-1, and the delay counter reloads at 0.

## Timing
- Reset values, applied immediately on `reset_i`:
  - `stage_reset_n_o` = all 0, `ready_o` = 0, `fault_o` = 0.
  - State = IDLE; all counters and sync flops = 0.
- Asserting `reset_i` at any point, including mid-RELEASE, forces these values with no clock needed.
- Lock latency: `pll_locked_i` high at edge n sets `lock_s` at edge n+1. The state becomes RELEASE at edge n+2 (entry edge E).
- Stage k releases at edge E+(k+1)·STAGE_DELAY.
- `ready_o` rises on the same edge as `stage_reset_n_o[STAGES-1]`.
- Lock loss: `pll_locked_i` low at edge n clears every stage bit and `ready_o` at edge n+2.
- Timeout: FAULT is entered LOCK_TIMEOUT edges after entering WAIT_LOCK. `fault_o` rises on that edge.
- All outputs are registered; none is combinational from any input.

## Configuration
- `RESET_SEQUENCER_RETRY_EN`.
- Undefined: FAULT is terminal until `reset_i`.
- Defined:
  - In FAULT, `lock_s`=1 → RELEASE, following the normal sequence.
  - `fault_o` stays high (sticky) until `reset_i`, even after reaching RUN.

## Test plan
All scenarios use STAGES=3, STAGE_DELAY=4, LOCK_TIMEOUT=32.
- Release sequence: deassert reset, then raise lock at edge 10 → RELEASE at edge 12; stages 0/1/2 release at edges 16/20/24; `ready_o`=1 at edge 24.
- Lock loss in RUN: drop lock at edge 40 → `stage_reset_n_o`=3'b000 and `ready_o`=0 at edge 42. Re-raise lock → full sequence again, 4-cycle spacing.
- Timeout: lock held low → `fault_o`=1 exactly 32 edges after entering WAIT_LOCK; outputs stay 0 for 100 more cycles. With RETRY_EN: raise lock → sequence completes and `fault_o` remains 1.
- Lock/timeout tie: `lock_s` rises on the cycle the counter equals 31 → RELEASE, `fault_o`=0.
- Async reset mid-RELEASE: pulse `reset_i` between edges 17 and 18 → outputs return to 0 before edge 18. After release, the sequence restarts from WAIT_LOCK.
- Lock glitch: 1-cycle low pulse during RELEASE after stage 0 is out → all stages reassert; k restarts at 0.
